mux8_scan_sequencer: RTL and testbench
======================================

Name: mux8_scan_sequencer

Overview:
Upstream control/capture stage for the 8-to-1 multiplexer (module mux_8).
- Drives the mux select lines s2,s1,s0 through channels 0..7.
- Holds each select for a programmable dwell time, then samples the mux output y.
- Assembles the eight samples into one byte and hands it to the consumer over a valid/ready handshake.
- Supports single-shot and continuous scanning, with a sticky overrun flag.

Parameters:
- DWELL, 2: cycles each select value is held before its sample is taken. Legal range 1..255; anything else is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; release is synchronised to clk by the system.
- start  input  1  single-cycle request to begin a scan; honoured only in IDLE.
- continuous  input  1  when 1 at frame end, the next frame starts immediately.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- y_in  input  1  mux output y.
- s0  output  1  select bit 0 (LSB) to the mux.
- s1  output  1  select bit 1 to the mux.
- s2  output  1  select bit 2 (MSB) to the mux.
- busy  output  1  high while a frame is in progress.
- data_out  output  8  assembled frame; bit k is the sample taken from channel k.
- data_valid  output  1  data_out holds an unconsumed frame.
- data_ready  input  1  consumer accepts data_out when both data_ready and data_valid are 1 at an edge.
- overrun  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; {s2,s1,s0}=0; busy=0; data_out=0x00; data_valid=0; overrun=0; internal channel counter, dwell counter and shift register=0.
- States: IDLE, SCAN.
- IDLE -> SCAN: at the edge where start=1. Set busy=1, ch=0, dwell cnt=0. Selects stay 0.
- IDLE with start=0: selects stay 0.
- SCAN, at each edge:
  - if cnt==DWELL-1: capture y_in into sample bit [ch], set cnt=0, ch=ch+1.
  - otherwise: cnt=cnt+1.
- {s2,s1,s0} always equals ch and changes only at a sample edge. Each channel's select is stable for exactly DWELL cycles before its sample edge.
- Frame end is the sample edge of ch=7. A frame spans 8*DWELL cycles, and data_valid rises 8*DWELL cycles after the start edge.
- At frame end, continuous=1: stay in SCAN with ch=0, busy stays 1, no idle gap.
- At frame end, continuous=0: go to IDLE, busy=0, selects return to 0.
- Output register at frame end:
  - data_valid=0, or data_ready=1 (consumption at the same edge): data_out gets the new byte; data_valid=1.
  - data_valid=1 and data_ready=0: new frame dropped; data_out unchanged; overrun=1.
- Handshake: data_valid is cleared at any edge with data_valid=1 and data_ready=1, unless a new frame completes at that same edge. data_out is stable while data_valid=1.
- start while busy: ignored, with no effect on ch, cnt or outputs.
- continuous: sampled only at the frame-end edge. Deasserting it mid-frame lets the current frame complete.
- overrun:
  - clr_overrun=1 clears it.
  - A simultaneous set and clear leaves overrun=1 (set wins).
  - overrun does not block scanning.
- Reset mid-frame: the partial frame is discarded; all outputs return to reset values immediately.
- DWELL=1: select advances every cycle and y_in is sampled every cycle.

Test Plan:
- Single shot: DWELL=1, bench mux model with i=0xA5, pulse start, data_ready=0 → selects step 0..7 one per cycle; data_valid=1 with data_out=0xA5 exactly 8 cycles after the start edge; busy=0 afterwards; selects=0.
- Dwell timing: DWELL=3, i=0x3C → each select value held 3 cycles; data_valid rises 24 cycles after start; data_out=0x3C. Changing the bench input during non-sample cycles of a channel does not affect the result.
- Continuous back-to-back: continuous=1, data_ready=1, i changes 0x01→0x80 between frames → frames every 8*DWELL cycles with no gap; data_out=0x01 then 0x80; overrun stays 0.
- Overrun: continuous=1, data_ready=0 → after the second frame end overrun=1 and data_out still holds frame 1. A clr_overrun pulse clears it. A clear coinciding with a third drop leaves overrun=1.
- Ignored start: start pulsed at ch=3 mid-frame → frame completes at the original time with the unchanged result.
- Async reset mid-frame: rst_n low at ch=5 between clock edges → all outputs 0 without waiting for an edge. A new start after release produces a full correct frame.

Source files
------------

// File: rtl/mux8_scan_sequencer_if.sv
// Frame output channel of the mux_8 scan sequencer: one byte per frame over valid/ready.
interface mux8_scan_sequencer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/mux8_scan_sequencer.sv
// Steps the mux_8 select lines through channels 0..7, samples y after DWELL cycles per
// channel and publishes each assembled byte over a valid/ready channel with a sticky overrun.
module mux8_scan_sequencer #(
    parameter int unsigned DWELL = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          continuous,
    input  logic                          clr_overrun,
    input  logic                          y_in,
    output logic                          s0,
    output logic                          s1,
    output logic                          s2,
    output logic                          busy,
    output logic                          overrun,
    mux8_scan_sequencer_if.master         out_if
);

    if (DWELL < 1 || DWELL > 255) begin : g_dwell_check
        $error("mux8_scan_sequencer: DWELL must be in 1..255");
    end

    typedef enum logic {IDLE, SCAN} state_e;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_e     state_q, state_d;
    logic [2:0] ch_q, ch_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;

    logic sample;
    logic frame_end;

    assign sample    = (state_q == SCAN) && (cnt_q == DWELL_LAST);
    assign frame_end = sample && (ch_q == 3'd7);

    // NOTE: every register, the sample shift register included, is cleared by reset so a
    // frame interrupted by rst_n leaves no stale bits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path through this block infers a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (sample) begin
                    shift_d[ch_q] = y_in;
                    cnt_d         = '0;
                    ch_d          = 3'(ch_q + 3'd1);  // wraps to 0 after channel 7
                    if (frame_end && !continuous) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && out_if.data_ready) begin
            valid_d = 1'b0;
        end

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        // A completed frame either replaces a consumed/empty slot or is dropped;
        // the drop is applied after the clear so a coincident set wins.
        if (frame_end) begin
            if (!valid_q || out_if.data_ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        {s2, s1, s0}      = ch_q;
        busy              = (state_q == SCAN);
        overrun           = overrun_q;
        out_if.data_out   = data_q;
        out_if.data_valid = valid_q;
    end

endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// Directed bench for mux8_scan_sequencer: a DWELL=1 and a DWELL=3 instance, each driven by
// a behavioural mux_8 model; frame vectors in a table plus hand-written multi-cycle sequences.
module tb_mux8_scan_sequencer;

    localparam int D1 = 1;
    localparam int D3 = 3;

    logic clk;
    logic rst_n;

    logic       start1, cont1, clr1, rdy1;
    logic [7:0] mux_i1;
    logic       y1, s0_1, s1_1, s2_1, busy1, ovr1;

    logic       start3, cont3, clr3, rdy3;
    logic [7:0] mux_i3;
    logic       y3, s0_3, s1_3, s2_3, busy3, ovr3;

    mux8_scan_sequencer_if if1 ();
    mux8_scan_sequencer_if if3 ();

    assign if1.data_ready = rdy1;
    assign if3.data_ready = rdy3;

    // Behavioural mux_8: y = i[{s2,s1,s0}]
    assign y1 = mux_i1[{s2_1, s1_1, s0_1}];
    assign y3 = mux_i3[{s2_3, s1_3, s0_3}];

    mux8_scan_sequencer #(.DWELL(D1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1),
        .clr_overrun(clr1), .y_in(y1), .s0(s0_1), .s1(s1_1), .s2(s2_1),
        .busy(busy1), .overrun(ovr1), .out_if(if1.master)
    );

    mux8_scan_sequencer #(.DWELL(D3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .continuous(cont3),
        .clr_overrun(clr3), .y_in(y3), .s0(s0_3), .s1(s1_3), .s2(s2_3),
        .busy(busy3), .overrun(ovr3), .out_if(if3.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        bit         dut3;
        logic [7:0] i_val;
        bit         corrupt;   // drive ~i_val on every non-sample cycle
        int         pulse_k;   // cycle of a mid-frame start pulse, -1 for none
        logic [7:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sel_of(input bit d3);
        return d3 ? {s2_3, s1_3, s0_3} : {s2_1, s1_1, s0_1};
    endfunction
    function automatic logic busy_of(input bit d3);
        return d3 ? busy3 : busy1;
    endfunction
    function automatic logic valid_of(input bit d3);
        return d3 ? if3.data_valid : if1.data_valid;
    endfunction
    function automatic logic [7:0] data_of(input bit d3);
        return d3 ? if3.data_out : if1.data_out;
    endfunction

    task automatic drive(input bit d3, input logic st, input logic rdy, input logic [7:0] iv);
        if (d3) begin
            start3 = st; rdy3 = rdy; mux_i3 = iv;
        end else begin
            start1 = st; rdy1 = rdy; mux_i1 = iv;
        end
    endtask

    // Single-shot frame: start, check selects/busy/valid every cycle, check the byte, consume it.
    task automatic run_frame(input vec_t v);
        int d;
        logic [7:0] iv;
        d = v.dut3 ? D3 : D1;
        drive(v.dut3, 1'b1, 1'b0, v.i_val);
        step();
        for (int k = 0; k < 8 * d; k++) begin
            check({v.name, "_sel"},   32'(sel_of(v.dut3)),   32'(k / d));
            check({v.name, "_busy"},  32'(busy_of(v.dut3)),  32'd1);
            check({v.name, "_valid"}, 32'(valid_of(v.dut3)), 32'd0);
            iv = (v.corrupt && (k % d != d - 1)) ? ~v.i_val : v.i_val;
            drive(v.dut3, (k == v.pulse_k), 1'b0, iv);
            step();
        end
        check({v.name, "_vrise"}, 32'(valid_of(v.dut3)), 32'd1);
        check({v.name, "_data"},  32'(data_of(v.dut3)),  32'(v.exp_data));
        check({v.name, "_idle"},  32'(busy_of(v.dut3)),  32'd0);
        check({v.name, "_sel0"},  32'(sel_of(v.dut3)),   32'd0);
        drive(v.dut3, 1'b0, 1'b1, v.i_val);
        step();
        check({v.name, "_consumed"}, 32'(valid_of(v.dut3)), 32'd0);
        drive(v.dut3, 1'b0, 1'b0, v.i_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{"d1_a5",    1'b0, 8'hA5, 1'b0, -1, 8'hA5};
        vecs[1] = '{"d1_00",    1'b0, 8'h00, 1'b0, -1, 8'h00};
        vecs[2] = '{"d1_ff",    1'b0, 8'hFF, 1'b0, -1, 8'hFF};
        vecs[3] = '{"d3_3c",    1'b1, 8'h3C, 1'b1, -1, 8'h3C};
        vecs[4] = '{"d3_96",    1'b1, 8'h96, 1'b1, -1, 8'h96};
        vecs[5] = '{"d3_start", 1'b1, 8'h5A, 1'b0, 10, 8'h5A};

        rst_n = 1'b0;
        start1 = 0; cont1 = 0; clr1 = 0; rdy1 = 0; mux_i1 = 8'h00;
        start3 = 0; cont3 = 0; clr3 = 0; rdy3 = 0; mux_i3 = 8'h00;
        #12;
        check("rst_sel",   32'(sel_of(1'b1)),   32'd0);
        check("rst_busy",  32'(busy3),          32'd0);
        check("rst_valid", 32'(valid_of(1'b1)), 32'd0);
        check("rst_data",  32'(data_of(1'b1)),  32'd0);
        check("rst_ovr",   32'(ovr3),           32'd0);
        check("rst_busy1", 32'(busy1),          32'd0);
        rst_n = 1'b1;
        step();
        check("idle_sel",  32'(sel_of(1'b1)),   32'd0);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Continuous back-to-back, consumer always ready, continuous dropped during frame 2
        cont3 = 1'b1; rdy3 = 1'b1; mux_i3 = 8'h01; start3 = 1'b1;
        step();
        start3 = 1'b0;
        repeat (23) step();
        check("cont_pre_valid", 32'(if3.data_valid), 32'd0);
        step();
        check("cont_f1_valid", 32'(if3.data_valid), 32'd1);
        check("cont_f1_data",  32'(if3.data_out),   32'h01);
        check("cont_f1_busy",  32'(busy3),          32'd1);
        check("cont_f1_sel",   32'(sel_of(1'b1)),   32'd0);
        mux_i3 = 8'h80;
        step();
        check("cont_f1_taken", 32'(if3.data_valid), 32'd0);
        check("cont_gapless",  32'(busy3),          32'd1);
        repeat (10) step();
        cont3 = 1'b0;
        repeat (13) step();
        check("cont_f2_valid", 32'(if3.data_valid), 32'd1);
        check("cont_f2_data",  32'(if3.data_out),   32'h80);
        check("cont_f2_idle",  32'(busy3),          32'd0);
        check("cont_ovr",      32'(ovr3),           32'd0);
        step();
        check("cont_f2_taken", 32'(if3.data_valid), 32'd0);
        rdy3 = 1'b0;

        // Overrun: consumer stalled, frames keep coming
        cont3 = 1'b1; mux_i3 = 8'h11; start3 = 1'b1;
        step();
        start3 = 1'b0;
        repeat (24) step();
        check("ovr_f1_valid", 32'(if3.data_valid), 32'd1);
        check("ovr_f1_data",  32'(if3.data_out),   32'h11);
        check("ovr_f1_flag",  32'(ovr3),           32'd0);
        mux_i3 = 8'h22;
        repeat (24) step();
        check("ovr_f2_flag",  32'(ovr3),           32'd1);
        check("ovr_f2_data",  32'(if3.data_out),   32'h11);
        check("ovr_f2_busy",  32'(busy3),          32'd1);
        clr3 = 1'b1;
        step();
        clr3 = 1'b0;
        check("ovr_cleared",  32'(ovr3),           32'd0);
        repeat (22) step();
        clr3 = 1'b1;
        step();
        clr3 = 1'b0;
        check("ovr_set_wins", 32'(ovr3),           32'd1);
        check("ovr_f3_data",  32'(if3.data_out),   32'h11);

        // Async reset while channel 5 is selected, between clock edges
        repeat (15) step();
        check("arst_pre_sel", 32'(sel_of(1'b1)), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sel",   32'(sel_of(1'b1)),   32'd0);
        check("arst_busy",  32'(busy3),          32'd0);
        check("arst_valid", 32'(if3.data_valid), 32'd0);
        check("arst_data",  32'(if3.data_out),   32'd0);
        check("arst_ovr",   32'(ovr3),           32'd0);
        cont3 = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        run_frame('{"arst_new", 1'b1, 8'hC3, 1'b1, -1, 8'hC3});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
